// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU issue definitions: control codes, MIPS opcode/funct values and the
// decoded-entry struct carried through the issue skid buffer.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SLL = 4'b1100;
  localparam logic [CTRL_W-1:0] ALU_SRL = 4'b1010;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              illegal;
  } alu_issue_t;

  function automatic alu_issue_t make_issue(input logic [CTRL_W-1:0] ctrl,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    alu_issue_t e;
    e.ctrl    = ctrl;
    e.a       = a;
    e.b       = b;
    e.illegal = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Combinational MIPS instruction + operand decode into an ALU issue entry.
// ALU_ISSUE_VSHIFT_EN adds sllv/srlv (shift amount taken from rs[4:0]).
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output alu_issue_t        dec
);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [DATA_W-1:0] shamt_zx;
  logic [DATA_W-1:0] imm_sx;
  logic [DATA_W-1:0] imm_zx;
  logic              unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign shamt_zx      = {{(DATA_W-5){1'b0}}, instr[10:6]};
  assign imm_sx        = {{(DATA_W-16){instr[15]}}, instr[15:0]};
  assign imm_zx        = {{(DATA_W-16){1'b0}}, instr[15:0]};
  // Register specifiers are resolved upstream; only their data arrives here.
  assign unused_fields = ^instr[25:16];

  always_comb begin
    dec.ctrl    = ALU_ADD;
    dec.a       = '0;
    dec.b       = '0;
    dec.illegal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_AND:          dec = make_issue(ALU_AND, rs_data, rt_data);
          FN_OR:           dec = make_issue(ALU_OR,  rs_data, rt_data);
          FN_ADD, FN_ADDU: dec = make_issue(ALU_ADD, rs_data, rt_data);
          FN_SUB, FN_SUBU: dec = make_issue(ALU_SUB, rs_data, rt_data);
          FN_SLL:          dec = make_issue(ALU_SLL, rt_data, shamt_zx);
          FN_SRL:          dec = make_issue(ALU_SRL, rt_data, shamt_zx);
`ifdef ALU_ISSUE_VSHIFT_EN
          FN_SLLV: dec = make_issue(ALU_SLL, rt_data, {{(DATA_W-5){1'b0}}, rs_data[4:0]});
          FN_SRLV: dec = make_issue(ALU_SRL, rt_data, {{(DATA_W-5){1'b0}}, rs_data[4:0]});
`endif
          default: ;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: dec = make_issue(ALU_ADD, rs_data, imm_sx);
      OP_ANDI:               dec = make_issue(ALU_AND, rs_data, imm_zx);
      OP_ORI:                dec = make_issue(ALU_OR,  rs_data, imm_zx);
      OP_BEQ:                dec = make_issue(ALU_SUB, rs_data, rt_data);
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes into ALU controls/operands behind a 2-entry skid
// buffer. Optional sllv/srlv decode is enabled by ALU_ISSUE_VSHIFT_EN.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              illegal
);

  // Handshake: a beat transfers on a rising edge where valid && ready are both
  // high; a held output (out_valid && !out_ready) keeps its payload unchanged,
  // and in_ready is derived from registered state only.

  alu_issue_t dec;
  alu_issue_t main_q;
  alu_issue_t skid_q;
  logic       main_v;
  logic       skid_v;
  logic       ready_en;
  logic       accept;

  alu_issue_decode u_decode (
    .instr   (instr),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .dec     (dec)
  );

  assign in_ready  = ready_en && !skid_v;
  assign accept    = in_valid && in_ready;
  assign out_valid = main_v;
  assign alu_ctrl  = main_q.ctrl;
  assign op_a      = main_q.a;
  assign op_b      = main_q.b;
  assign illegal   = main_q.illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v   <= 1'b0;
      skid_v   <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
      end else if (!main_v || out_ready) begin
        // Main is free this edge; the skid entry is older, so it goes first.
        // accept implies an empty skid, so no input is lost in that branch.
        if (skid_v) begin
          main_q <= skid_q;
          main_v <= 1'b1;
          skid_v <= 1'b0;
        end else begin
          main_v <= accept;
          if (accept) main_q <= dec;
        end
      end else if (accept) begin
        skid_q <= dec;
        skid_v <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed literal vectors, then randomized traffic
// against a queue-based reference of a 2-deep in-order buffer.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  // Expected entries {ctrl[68:65], a[64:33], b[32:1], illegal[0]}
  logic [68:0] exp_q[$];
  logic        ready_ok;

  alu_issue_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .illegal   (illegal)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [68:0] ref_decode(input logic [31:0] ins,
                                             input logic [31:0] rs,
                                             input logic [31:0] rt);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] sh;
    logic [31:0] sx;
    logic [31:0] zx;
    op = ins[31:26];
    fn = ins[5:0];
    sh = 32'(ins[10:6]);
    zx = 32'(ins[15:0]);
    sx = {{16{ins[15]}}, ins[15:0]};
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h21)) return {4'b0010, rs, rt, 1'b0};
    if (op == 6'h00 && (fn == 6'h22 || fn == 6'h23)) return {4'b0100, rs, rt, 1'b0};
    if (op == 6'h00 && fn == 6'h24) return {4'b0000, rs, rt, 1'b0};
    if (op == 6'h00 && fn == 6'h25) return {4'b0001, rs, rt, 1'b0};
    if (op == 6'h00 && fn == 6'h00) return {4'b1100, rt, sh, 1'b0};
    if (op == 6'h00 && fn == 6'h02) return {4'b1010, rt, sh, 1'b0};
`ifdef ALU_ISSUE_VSHIFT_EN
    if (op == 6'h00 && fn == 6'h04) return {4'b1100, rt, 32'(rs[4:0]), 1'b0};
    if (op == 6'h00 && fn == 6'h06) return {4'b1010, rt, 32'(rs[4:0]), 1'b0};
`endif
    if (op == 6'h08 || op == 6'h23 || op == 6'h2B) return {4'b0010, rs, sx, 1'b0};
    if (op == 6'h0C) return {4'b0000, rs, zx, 1'b0};
    if (op == 6'h0D) return {4'b0001, rs, zx, 1'b0};
    if (op == 6'h04) return {4'b0100, rs, rt, 1'b0};
    return {4'b0010, 32'd0, 32'd0, 1'b1};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int n;
    if (!rst_n) begin
      exp_q.delete();
      ready_ok = 1'b0;
    end else begin
      n = exp_q.size();
      if (flush) begin
        exp_q.delete();
      end else begin
        if (n > 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && ready_ok && n < 2) exp_q.push_back(ref_decode(instr, rs_data, rt_data));
      end
      ready_ok = 1'b1;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [68:0] e;
    if (rst_n) begin
      check("cmp_out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      check("cmp_in_ready", 32'(in_ready), 32'(ready_ok && exp_q.size() < 2));
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        check("cmp_ctrl", 32'(alu_ctrl), 32'(e[68:65]));
        check("cmp_op_a", op_a, e[64:33]);
        check("cmp_op_b", op_b, e[32:1]);
        check("cmp_illegal", 32'(illegal), 32'(e[0]));
      end
    end
  end

  // ---------------- drivers ----------------
  function automatic logic [31:0] r_instr(input logic [5:0] fn, input logic [4:0] sh);
    return {6'h00, 5'd1, 5'd2, 5'd3, sh, fn};
  endfunction

  function automatic logic [31:0] i_instr(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0]  fns[10];
    logic [5:0]  ops[7];
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h00, 6'h02, 6'h04, 6'h06};
    ops = '{6'h08, 6'h23, 6'h2B, 6'h0C, 6'h0D, 6'h04, 6'h3F};
    r = $urandom;
    case ($urandom_range(0, 2))
      0: return {6'h00, r[25:6], fns[$urandom_range(0, 9)]};
      1: return {ops[$urandom_range(0, 6)], r[25:0]};
      default: return r;
    endcase
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  // One instruction through an empty stage; checks DUT and model against literals.
  task automatic directed(input string name, input logic [31:0] ins, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic ill);
    logic [68:0] m;
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    instr     = ins;
    rs_data   = rs;
    rt_data   = rt;
    @(negedge clk);
    in_valid = 1'b0;
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_ctrl"}, 32'(alu_ctrl), 32'(c));
    check({name, "_a"}, op_a, a);
    check({name, "_b"}, op_b, b);
    check({name, "_ill"}, 32'(illegal), 32'(ill));
    m = ref_decode(ins, rs, rt);
    check({name, "_model"}, 32'(m != {c, a, b, ill}), 32'd0);
  endtask

  task automatic push(input logic [31:0] rs);
    instr    = r_instr(6'h20, 5'd0);
    rs_data  = rs;
    rt_data  = 32'd7;
    in_valid = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    instr     = '0;
    rs_data   = '0;
    rt_data   = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_ctrl", 32'(alu_ctrl), 32'd0);
    check("rst_op_a", op_a, 32'd0);
    check("rst_op_b", op_b, 32'd0);
    #2 rst_n = 1'b1;
    idle(2);

    directed("add", r_instr(6'h20, 5'd0), 32'd5, 32'd3, 4'b0010, 32'd5, 32'd3, 1'b0);
    directed("addi", i_instr(6'h08, 16'hFFFF), 32'd10, 32'd9, 4'b0010, 32'd10, 32'hFFFF_FFFF, 1'b0);
    directed("ori", i_instr(6'h0D, 16'hFFFF), 32'd10, 32'd9, 4'b0001, 32'd10, 32'h0000_FFFF, 1'b0);
    directed("sll", r_instr(6'h00, 5'd4), 32'd8, 32'd1, 4'b1100, 32'd1, 32'd4, 1'b0);
    directed("bad_op", {6'h3F, 26'h155_5555}, 32'd8, 32'd1, 4'b0010, 32'd0, 32'd0, 1'b1);
    directed("beq", i_instr(6'h04, 16'h0010), 32'd20, 32'd6, 4'b0100, 32'd20, 32'd6, 1'b0);
`ifdef ALU_ISSUE_VSHIFT_EN
    directed("sllv", r_instr(6'h04, 5'd9), 32'd33, 32'd7, 4'b1100, 32'd7, 32'd1, 1'b0);
`else
    directed("sllv", r_instr(6'h04, 5'd9), 32'd33, 32'd7, 4'b0010, 32'd0, 32'd0, 1'b1);
`endif
    idle(2);

    // Back-pressure: three back-to-back inputs while EX stalls
    @(negedge clk); out_ready = 1'b0; push(32'd1);
    @(negedge clk); push(32'd2);
    @(negedge clk); push(32'd3);
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    check("bp_first_held", op_a, 32'd1);
    @(negedge clk);
    check("bp_still_first", op_a, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_second", op_a, 32'd2);
    check("bp_ready_back", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_third", op_a, 32'd3);
    idle(2);

    // Flush with the buffer full and a same-cycle input
    @(negedge clk); out_ready = 1'b0; push(32'd4);
    @(negedge clk); push(32'd5);
    @(negedge clk); push(32'd6); flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    idle(3);
    check("flush_nothing_after", 32'(out_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      instr     = rand_instr();
      rs_data   = $urandom;
      rt_data   = $urandom;
    end
    idle(3);

    // Asynchronous reset between edges with entries held
    @(negedge clk); out_ready = 1'b0; push(32'h55);
    @(negedge clk); push(32'h66);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_ctrl", 32'(alu_ctrl), 32'd0);
    check("arst_op_a", op_a, 32'd0);
    check("arst_op_b", op_b, 32'd0);
    check("arst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(2);
    check("arst_ready_after", 32'(in_ready), 32'd1);
    directed("post_rst_add", r_instr(6'h21, 5'd0), 32'd100, 32'd23, 4'b0010, 32'd100, 32'd23, 1'b0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer side of the ALU interface: decodes a MIPS instruction plus register-file operands into the 4-bit ALU control code and the two 32-bit ALU operands.
- Sits at the ID/EX boundary of the 6-stage pipeline; its outputs drive the ALU's A, B and ALUctrl inputs.
- A 2-entry skid buffer with valid/ready handshakes on both sides lets stalls propagate without dropping instructions.

Parameters:
- DATA_W, 32, operand width
- CTRL_W, 4, ALU control code width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode-side instruction valid
- in_ready  out  1  stage can accept an instruction this cycle
- instr  in  32  instruction word
- rs_data  in  DATA_W  register rs value
- rt_data  in  DATA_W  register rt value
- flush  in  1  branch/exception flush; discards all held entries
- out_valid  out  1  op_a/op_b/alu_ctrl valid
- out_ready  in  1  EX stage accepts this cycle
- alu_ctrl  out  CTRL_W  ALU control code
- op_a  out  DATA_W  ALU operand A
- op_b  out  DATA_W  ALU operand B
- illegal  out  1  entry is an undecodable instruction

Behaviour:
- ALU control codes: AND=0000, OR=0001, ADD=0010, SUB=0100, SLL=1100, SRL=1010.
- Decode uses opcode=instr[31:26], funct=instr[5:0], shamt=instr[10:6], imm=instr[15:0]. Combinational decode feeds the buffer:
  - R-type (opcode 0):
    - funct 24h: AND, A=rs, B=rt.
    - funct 25h: OR, A=rs, B=rt.
    - funct 20h/21h: ADD, A=rs, B=rt.
    - funct 22h/23h: SUB, A=rs, B=rt.
    - funct 00h: SLL, A=rt, B=zero-extended shamt.
    - funct 02h: SRL, A=rt, B=zero-extended shamt.
  - I-type:
    - opcode 08h (addi), 23h (lw), 2Bh (sw): ADD, B=sign-extended imm.
    - opcode 0Ch (andi): AND, B=zero-extended imm.
    - opcode 0Dh (ori): OR, B=zero-extended imm.
    - opcode 04h (beq): SUB, A=rs, B=rt.
    - All other I-type opcodes listed here take A=rs.
  - Anything else: illegal=1, alu_ctrl=ADD, op_a=op_b=0.
- Latency: 1 cycle from accepted input to out_valid when the buffer is empty.
- Handshake:
  - Transfer occurs when valid&&ready on the same edge.
  - Outputs stay stable while out_valid&&!out_ready.
  - in_ready depends only on registered occupancy (no combinational path from out_ready).
- Buffer: main register (drives outputs) plus one skid register.
  - in_ready=1 iff the skid is empty.
  - An input accepted while the main register is held goes to the skid.
  - When the main register drains, the skid moves into main on the same edge.
  - Order is strictly FIFO.
- Simultaneous accept and drain with skid empty: new entry loads main; out_valid stays 1.
- Full: main and skid both occupied gives in_ready=0; in_valid is ignored.
- flush: on the edge it is sampled high, both entries are invalidated and any same-cycle input is discarded. The next cycle has out_valid=0, in_ready=1.
- Reset (async, any time including mid-transfer): all outputs go to 0 immediately (out_valid, alu_ctrl, op_a, op_b, illegal), in_ready=0 while rst_n=0. in_ready=1 from the first clock after release.

Optional Feature:
- Macro ALU_ISSUE_VSHIFT_EN.
- Defined: R-type funct 04h (sllv) gives SLL and funct 06h (srlv) gives SRL, with A=rt, B={27'b0, rs[4:0]}.
- Undefined: funct 04h/06h decode as illegal.

Decomposition:
- Package alu_pkg holds:
  - ALU control code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL).
  - Opcode/funct constants.
  - Packed struct alu_issue_t {ctrl, a, b, illegal}.
- Natural sub-module: alu_issue_decode, a purely combinational instr/rs/rt to alu_issue_t mapping. The top holds the skid buffer and handshake.

Test Plan:
- rs=5, rt=3, instr=add (funct 20h), out_ready=1 -> next cycle out_valid=1, alu_ctrl=0010, op_a=5, op_b=3, illegal=0.
- addi imm=FFFFh, rs=10 -> alu_ctrl=0010, op_b=FFFFFFFFh. ori imm=FFFFh -> alu_ctrl=0001, op_b=0000FFFFh.
- sll shamt=4, rt=1 -> alu_ctrl=1100, op_a=1, op_b=4. opcode 3Fh -> illegal=1, ctrl=0010, op_a=op_b=0.
- out_ready=0, three back-to-back valid inputs:
  - First two are accepted; in_ready=0 on the third.
  - Then raise out_ready: outputs emerge in order 1, 2, and the third is accepted after in_ready rises.
- Buffer full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and nothing emerges afterward.
- rst_n low mid-stream between edges -> outputs 0 immediately. With ALU_ISSUE_VSHIFT_EN, sllv rs=33 -> op_b=1, ctrl=1100; without the macro -> illegal=1.
